// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared definitions for the traffic density classifier and
//                the intersection light controller: lane count, lane class
//                encoding, default thresholds and the window classification
//                rule.
//  Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    localparam int NUM_LANES = 3;

    // Default window / threshold settings, shared with the controller bench
    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_WIN_TICKS  = 30;
    localparam int DEF_CNT_W      = 6;
    localparam int DEF_TH_LOW     = 3;
    localparam int DEF_TH_HIGH    = 10;
    localparam int DEF_HYST       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LIGHT = 2'd1,
        HEAVY = 2'd2
    } lane_class_t;

    // Next class of a lane at window close. A lane already HEAVY stays HEAVY
    // down to TH_HIGH-HYST arrivals, so a borderline lane does not toggle.
    function automatic lane_class_t classify(
        input lane_class_t cur,
        input int          cnt,
        input int          th_low,
        input int          th_high,
        input int          hyst
    );
        int keep_heavy;
        keep_heavy = (cur == HEAVY) ? (th_high - hyst) : th_high;
        if (cnt >= keep_heavy) begin
            classify = HEAVY;
        end else if (cnt >= th_low) begin
            classify = LIGHT;
        end else begin
            classify = IDLE;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : lane_debounce
//  Description : One detector lane: 2-FF synchroniser, debounce filter and
//                registered rising-edge (arrival) pulse.
//  Ports       : clk      - system clock
//                reset    - synchronous, active-high
//                det_i    - raw asynchronous detector level
//                rise_o   - one-clock pulse on a debounced rising edge
//  Revision    : 1.0  initial release
// ============================================================================
module lane_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic det_i,
    output logic rise_o
);

    localparam int             DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [DW-1:0] stab_q,  stab_d;
    logic          rise_q,  rise_d;

    // The stable counter runs only while the synchronised value disagrees
    // with the debounced level; any agreement (a glitch back) zeroes it.
    // The level flips on the DEB_CYCLES-th consecutive disagreeing clock.
    always_comb begin
        level_d = level_q;
        stab_d  = '0;
        if (sync2_q != level_q) begin
            if (stab_q == DEB_LAST) begin
                level_d = sync2_q;
            end else begin
                stab_d = stab_q + DW'(1);
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            stab_q  <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= det_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            stab_q  <= stab_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/traffic_density_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_density_classifier
//  Description : Counts debounced vehicle arrivals per lane over a window of
//                WIN_TICKS timebase ticks and reclassifies every lane as
//                IDLE / LIGHT / HEAVY at each window close.
//  Ports       : clk    - system clock
//                reset  - synchronous, active-high
//                tick   - one-clock 1 s strobe
//                det    - raw detector levels, bit i = lane i
//                L      - lane is LIGHT (registered)
//                H      - lane is HEAVY (registered)
//                upd    - one-clock pulse when L/H were just reloaded
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_density_classifier
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int WIN_TICKS  = DEF_WIN_TICKS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TH_LOW     = DEF_TH_LOW,
    parameter int TH_HIGH    = DEF_TH_HIGH,
    parameter int HYST       = DEF_HYST
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [NUM_LANES-1:0] det,
    output logic [NUM_LANES-1:0] L,
    output logic [NUM_LANES-1:0] H,
    output logic                 upd
);

    localparam int                WW       = $clog2(WIN_TICKS);
    localparam logic [WW-1:0]     WIN_LAST = WW'(WIN_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [NUM_LANES-1:0] rise_w;
    logic                 close_w;

    logic [WW-1:0]        wcnt_q, wcnt_d;
    logic [CNT_W-1:0]     cnt_q   [NUM_LANES];
    logic [CNT_W-1:0]     cnt_d   [NUM_LANES];
    lane_class_t          class_q [NUM_LANES];
    lane_class_t          class_d [NUM_LANES];
    logic                 close_q;
    logic [NUM_LANES-1:0] L_q, L_d;
    logic [NUM_LANES-1:0] H_q, H_d;
    logic                 upd_q;

    // ------------------------------------------------------------------
    // Per-lane front end
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            lane_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk    (clk),
                .reset  (reset),
                .det_i  (det[i]),
                .rise_o (rise_w[i])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Window counter
    // ------------------------------------------------------------------
    assign close_w = tick && (wcnt_q == WIN_LAST);

    always_comb begin
        wcnt_d = wcnt_q;
        if (tick) begin
            wcnt_d = close_w ? '0 : (wcnt_q + WW'(1));
        end
    end

    // ------------------------------------------------------------------
    // Arrival counters and class FSMs (next state)
    // ------------------------------------------------------------------
    // The classification sees the count before this cycle's arrival; an
    // arrival in the closing cycle seeds the new window with 1 instead.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            cnt_d[i]   = cnt_q[i];
            class_d[i] = class_q[i];
            if (close_w) begin
                cnt_d[i]   = rise_w[i] ? CNT_W'(1) : '0;
                class_d[i] = classify(class_q[i], int'(cnt_q[i]),
                                      TH_LOW, TH_HIGH, HYST);
            end else if (rise_w[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Output decode from the class registers; since the class only moves at
    // window close, L/H follow one clock after it, together with upd.
    always_comb begin
        L_d = '0;
        H_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            L_d[i] = (class_q[i] == LIGHT);
            H_d[i] = (class_q[i] == HEAVY);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q  <= '0;
            close_q <= 1'b0;
            L_q     <= '0;
            H_q     <= '0;
            upd_q   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                cnt_q[i]   <= '0;
                class_q[i] <= IDLE;
            end
        end else begin
            wcnt_q  <= wcnt_d;
            close_q <= close_w;
            L_q     <= L_d;
            H_q     <= H_d;
            upd_q   <= close_q;
            for (int i = 0; i < NUM_LANES; i++) begin
                cnt_q[i]   <= cnt_d[i];
                class_q[i] <= class_d[i];
            end
        end
    end

    assign L   = L_q;
    assign H   = H_q;
    assign upd = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_density_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_density_classifier
//  Description : Directed self-checking bench for traffic_density_classifier
//                with hand-computed expected lane classes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_density_classifier;
    import traffic_pkg::*;

    localparam int WIN = DEF_WIN_TICKS;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic [2:0] det   = 3'b000;
    logic [2:0] L;
    logic [2:0] H;
    logic       upd;

    int n_tests = 0;
    int n_fail  = 0;
    int wcnt_m  = 0;

    traffic_density_classifier #(
        .DEB_CYCLES (DEF_DEB_CYCLES),
        .WIN_TICKS  (DEF_WIN_TICKS),
        .CNT_W      (DEF_CNT_W),
        .TH_LOW     (DEF_TH_LOW),
        .TH_HIGH    (DEF_TH_HIGH),
        .HYST       (DEF_HYST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .det   (det),
        .L     (L),
        .H     (H),
        .upd   (upd)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // n clean arrivals on one lane: 6 clocks high, 6 clocks low
    task automatic arrive(input int lane, input int n);
        repeat (n) begin
            @(negedge clk) det[lane] = 1'b1;
            repeat (6) @(negedge clk);
            det[lane] = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    // n ticks on consecutive cycles
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick = 1'b1;
        end
        @(negedge clk) tick = 1'b0;
        wcnt_m = (wcnt_m + n) % WIN;
    endtask

    // Called at the negedge right after the closing tick was sampled
    task automatic check_close(input logic [2:0] exp_l, input logic [2:0] exp_h,
                               input string tag);
        check_eq({tag, ".upd_early"}, upd, 1'b0);
        @(negedge clk);
        check_eq({tag, ".upd"}, upd, 1'b1);
        check_eq({tag, ".L"},   L,   exp_l);
        check_eq({tag, ".H"},   H,   exp_h);
        @(negedge clk);
        check_eq({tag, ".upd_end"}, upd, 1'b0);
    endtask

    task automatic close_window(input logic [2:0] exp_l, input logic [2:0] exp_h,
                                input string tag);
        for (int i = 0; i < WIN - wcnt_m; i++) begin
            @(negedge clk) tick = 1'b1;
        end
        @(negedge clk) tick = 1'b0;
        wcnt_m = 0;
        check_close(exp_l, exp_h, tag);
    endtask

    initial begin
        // Reset for 3 clocks with all detectors active and a tick pending
        reset = 1'b1;
        det   = 3'b111;
        tick  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst.L",   L,   3'b000);
        check_eq("rst.H",   H,   3'b000);
        check_eq("rst.upd", upd, 1'b0);
        check_eq("rst.wcnt", dut.wcnt_q, 0);
        reset = 1'b0;
        det   = 3'b000;
        tick  = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("rst.cnt0", dut.cnt_q[0], 0);
        check_eq("rst.cnt1", dut.cnt_q[1], 0);
        check_eq("rst.cnt2", dut.cnt_q[2], 0);

        // Debounce: 3-clock pulse rejected, 4-clock pulse accepted
        @(negedge clk) det[0] = 1'b1;
        repeat (3) @(negedge clk);
        det[0] = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("deb3.cnt0", dut.cnt_q[0], 0);
        @(negedge clk) det[0] = 1'b1;
        repeat (4) @(negedge clk);
        det[0] = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("deb4.cnt0", dut.cnt_q[0], 1);

        // Classification: 12 / 5 / 1 arrivals
        arrive(0, 11);
        arrive(1, 5);
        arrive(2, 1);
        check_eq("cls.cnt0", dut.cnt_q[0], 12);
        check_eq("cls.cnt1", dut.cnt_q[1], 5);
        check_eq("cls.midL", L, 3'b000);
        run_ticks(10);
        close_window(3'b010, 3'b001, "cls");

        // Hysteresis: 8 keeps HEAVY, 7 drops to LIGHT; lane 2 from IDLE/LIGHT
        arrive(0, 8);
        arrive(2, 3);
        check_eq("hold.H", H, 3'b001);
        check_eq("hold.L", L, 3'b010);
        close_window(3'b100, 3'b001, "hy8");
        arrive(0, 7);
        arrive(2, 9);
        close_window(3'b101, 3'b000, "hy7");

        // Arrival in the closing cycle belongs to the next window
        arrive(0, 2);
        run_ticks(WIN - 1);
        @(negedge clk) det[0] = 1'b1;
        repeat (6) @(negedge clk);
        tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        wcnt_m = 0;
        check_eq("bnd.cnt0", dut.cnt_q[0], 1);
        check_close(3'b000, 3'b000, "bnd");
        det[0] = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("bnd.held", dut.cnt_q[0], 1);
        arrive(0, 2);
        close_window(3'b001, 3'b000, "bnd2");

        // Saturation: 70 arrivals hold at 63
        arrive(0, 70);
        check_eq("sat.cnt0", dut.cnt_q[0], 63);
        close_window(3'b000, 3'b001, "sat");

        // Reset mid-window at tick 20, with a tick during reset
        arrive(1, 9);
        run_ticks(20);
        @(negedge clk) begin
            reset = 1'b1;
            tick  = 1'b1;
        end
        @(negedge clk) tick = 1'b0;
        @(negedge clk) reset = 1'b0;
        wcnt_m = 0;
        check_eq("rmw.L",    L,   3'b000);
        check_eq("rmw.H",    H,   3'b000);
        check_eq("rmw.upd",  upd, 1'b0);
        check_eq("rmw.cnt1", dut.cnt_q[1], 0);
        check_eq("rmw.wcnt", dut.wcnt_q, 0);
        arrive(1, 3);
        run_ticks(WIN - 1);
        check_eq("rmw.noclose.L", L, 3'b000);
        check_eq("rmw.noclose.H", H, 3'b000);
        close_window(3'b010, 3'b000, "rmw");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/traffic_density_classifier.md
# traffic_density_classifier

Upstream stage of the intersection light controller. It converts raw per-lane vehicle-detector levels into the per-lane light/heavy traffic flags `L[2:0]` and `H[2:0]` that the controller uses to choose its initial phase. Each detector is synchronised and debounced, and rising edges (vehicle arrivals) are counted over a fixed window of 1 s ticks. At each window close, every lane is reclassified as IDLE, LIGHT or HEAVY, with hysteresis on leaving HEAVY.

## Interface
Parameters:
- `DEB_CYCLES`, 4: consecutive stable clocks required before a debounced level changes (≥2)
- `WIN_TICKS`, 30: `tick` strobes per sampling window (≥2)
- `CNT_W`, 6: width of each per-lane arrival counter
- `TH_LOW`, 3: arrivals per window for LIGHT
- `TH_HIGH`, 10: arrivals per window for HEAVY (TH_HIGH > TH_LOW)
- `HYST`, 2: HEAVY is kept while count ≥ TH_HIGH−HYST (HYST < TH_HIGH−TH_LOW)

Ports:
- `clk`, in, 1: single system clock
- `reset`, in, 1: synchronous, active-high
- `tick`, in, 1: one-clock 1 s strobe from the timebase
- `det`, in, 3: raw asynchronous detector levels, one bit per lane (bit0 = lane 0)
- `L`, out, 3: lane is LIGHT (registered)
- `H`, out, 3: lane is HEAVY (registered)
- `upd`, out, 1: one-clock pulse when `L`/`H` were just reloaded

## Operation
- Per lane: 2-FF synchroniser, then debounce.
  - Debounced level takes the synchronised value after it differs from the current debounced level for `DEB_CYCLES` consecutive clocks.
  - Any glitch back to the current debounced level restarts the stable count.
- Arrival = rising edge of the debounced level. The lane counter increments and saturates at 2^CNT_W−1 (no wrap).
- Window counter `wcnt` runs 0..WIN_TICKS−1 and advances only on `tick`. A `tick` with `wcnt == WIN_TICKS−1` closes the window and `wcnt` returns to 0.
- At window close, per-lane class FSM (IDLE / LIGHT / HEAVY) with count c:
  - From IDLE or LIGHT: c ≥ TH_HIGH → HEAVY; else c ≥ TH_LOW → LIGHT; else IDLE.
  - From HEAVY: c ≥ TH_HIGH−HYST → HEAVY; else c ≥ TH_LOW → LIGHT; else IDLE.
- Outputs: `L[i]` = (class == LIGHT), `H[i]` = (class == HEAVY). `L[i]` and `H[i]` are never both 1.
- After classification, lane counters clear for the new window.
- An arrival in the closing cycle belongs to the new window: the counter loads 1 instead of 0 and that arrival is not included in the classification.
- Between window closes, the class is unchanged regardless of counter activity.

## Timing
- Reset: `L` = 0, `H` = 0, `upd` = 0, all classes IDLE, lane counters 0, `wcnt` = 0, debounced levels 0, synchronisers 0.
- Reset asserted mid-window discards the partial window. The first window after reset is a full `WIN_TICKS` ticks.
- Detector latency: a `det` change held steady reaches the debounced level 2 + DEB_CYCLES clocks later. The counter increments on the following clock edge.
- Closing `tick` sampled at edge N: `L`, `H` and `upd` = 1 are visible after edge N+1; `upd` returns to 0 after edge N+2.
- `tick` asserted on consecutive cycles: each cycle counts as a separate tick.
- `tick` concurrent with `reset`: `reset` wins.
- Debounced falling edges are never counted. A level held high counts once.

## Structure
- Shared package `traffic_pkg`:
  - `NUM_LANES` = 3
  - enum `lane_class_t` {IDLE, LIGHT, HEAVY}
  - default threshold constants, reused by the controller bench
- Sub-module `lane_debounce`: synchroniser, debounce counter and rising-edge pulse for one lane, parameterised by `DEB_CYCLES`. Instantiated `NUM_LANES` times.
- The top level holds the window counter, the lane counters and the class FSMs.

## Test plan
- **Reset values:** assert `reset` for 3 clocks with `det` = 3'b111 → `L` = `H` = 0, `upd` = 0, and no count is retained after release.
- **Debounce:** with DEB_CYCLES = 4, a 3-clock pulse on `det[0]` → no arrival. A 4-clock pulse → exactly 1 arrival.
- **Classification:** over one window, 12 arrivals on lane 0, 5 on lane 1, 1 on lane 2 → after the closing tick, `H` = 3'b001, `L` = 3'b010, `upd` = 1 for one clock.
- **Hysteresis:** lane 0 is HEAVY; next windows give 8 and then 7 arrivals → still HEAVY after the 8-arrival window, LIGHT after the 7-arrival window.
- **Boundary and saturation:** an arrival in the closing cycle → counted in the next window only. 70 arrivals with CNT_W = 6 → counter holds 63 and the lane is HEAVY.
- **Reset mid-window:** 9 arrivals, then reset at tick 20 → counts are discarded and the next window starts from `wcnt` = 0.
